// File: rtl/mips_pipeline_decode_register.sv
`default_nettype none
// ============================================================================
// Module   : mips_pipeline_decode_register
// Purpose  : Fetch-to-decode pipeline register built as a 2-entry skid
//            buffer (main entry drives the outputs, skid entry absorbs one
//            extra instruction when decode stalls). Strict FIFO order,
//            single-cycle latency, flush discards everything held.
// Ports    : clock, resetN (async active-low)
//            inValid/inReady/inInst/inPc   - fetch side handshake + payload
//            flush                         - discard held entries
//            outValid/outReady/outInst/outPc - decode side handshake + head
//            outOp/outFunc/outRs/outRt/outRd/outShamt/outImm - decoded fields
//            stallCount (only with MIPS_PIPELINE_DECODE_STALL_COUNT_EN)
// Options  : `define MIPS_PIPELINE_DECODE_STALL_COUNT_EN adds a saturating
//            16-bit count of cycles where the head entry waited on decode.
// Revision : 1.0 - initial release
// ============================================================================
module mips_pipeline_decode_register #(
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] inInst,
  input  logic [31:0] inPc,
  input  logic        flush,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outInst,
  output logic [31:0] outPc,
  output logic [5:0]  outOp,
  output logic [5:0]  outFunc,
  output logic [4:0]  outRs,
  output logic [4:0]  outRt,
  output logic [4:0]  outRd,
  output logic [4:0]  outShamt,
  output logic [15:0] outImm
`ifdef MIPS_PIPELINE_DECODE_STALL_COUNT_EN
  ,
  output logic [15:0] stallCount
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_in_ready;
  logic [31:0] r_main_inst;
  logic [31:0] r_main_pc;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;
  logic        w_accept;
  logic        w_pop;

  assign w_accept = inValid && r_in_ready;
  assign w_pop    = (r_state != S_EMPTY) && outReady;

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_next = S_ONE;
        S_ONE: begin
          if (w_accept && !w_pop)      w_state_next = S_FULL;
          else if (!w_accept && w_pop) w_state_next = S_EMPTY;
        end
        S_FULL:  if (w_pop) w_state_next = S_ONE;
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  // inReady is registered from the next state so fetch sees a clean flop;
  // it stays low during reset and rises on the first edge afterwards.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b0;
      r_main_inst <= BUBBLE_INST;
      r_main_pc   <= 32'h0;
      r_skid_inst <= BUBBLE_INST;
      r_skid_pc   <= 32'h0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != S_FULL);
      if (!flush) begin
        case (r_state)
          S_EMPTY: begin
            if (w_accept) begin
              r_main_inst <= inInst;
              r_main_pc   <= inPc;
            end
          end
          S_ONE: begin
            // Accept+pop replaces the head directly; accept alone parks
            // the newcomer in the skid slot behind the stalled head.
            if (w_accept && w_pop) begin
              r_main_inst <= inInst;
              r_main_pc   <= inPc;
            end else if (w_accept) begin
              r_skid_inst <= inInst;
              r_skid_pc   <= inPc;
            end
          end
          S_FULL: begin
            if (w_pop) begin
              r_main_inst <= r_skid_inst;
              r_main_pc   <= r_skid_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign inReady  = r_in_ready;
  assign outValid = (r_state != S_EMPTY);
  assign outInst  = outValid ? r_main_inst : BUBBLE_INST;
  assign outPc    = outValid ? r_main_pc   : 32'h0;

  assign outOp    = outInst[31:26];
  assign outRs    = outInst[25:21];
  assign outRt    = outInst[20:16];
  assign outRd    = outInst[15:11];
  assign outShamt = outInst[10:6];
  assign outFunc  = outInst[5:0];
  assign outImm   = outInst[15:0];

`ifdef MIPS_PIPELINE_DECODE_STALL_COUNT_EN
  logic [15:0] r_stall_count;

  // Counts head-entry stalls since reset; flush deliberately has no effect.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_stall_count <= 16'h0;
    end else if (outValid && !outReady && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stallCount = r_stall_count;
`endif

endmodule
`default_nettype wire
